prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter CLK_HZ, default 50000000, SHALL be the frequency of CLK in Hz.
REQ-002 Parameter BAUD, default 115200, SHALL be the serial bit rate; bit period DIV = CLK_HZ/BAUD clocks (integer division, DIV >= 4).
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 clr_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 rxd  input  1  SHALL be the asynchronous serial input: idle high, 8N1, LSB first.
REQ-006 addr  input  4  SHALL be the CPU program-fetch address.
REQ-007 data  output  8  SHALL be the instruction word returned for addr.
REQ-008 loading  output  1  SHALL be high while a program load is in progress; the CPU is held while it is high.
REQ-009 load_done  output  1  SHALL pulse high one cycle when a complete program has been written.
REQ-010 err  output  1  SHALL be a sticky framing-error flag.

Function
REQ-011 Block SHALL contain a 16 x 8 program memory: written only by the loader, read by the CPU.
REQ-012 data SHALL equal mem[addr] combinationally when loading=0, and 8'h00 when loading=1.
REQ-013 rxd SHALL pass through a 2-flop synchronizer before any use; only the synchronized value is sampled.
REQ-014 Receiver FSM states: IDLE, START, DATA, STOP.
REQ-015 IDLE -> START on synchronized rxd=0; a bit counter is cleared on entry.
REQ-016 START: sample at DIV/2 clocks; rxd=1 -> IDLE (false start, no error), rxd=0 -> DATA.
REQ-017 DATA: sample every DIV clocks, 8 samples; the first goes to bit 0; after the 8th -> STOP.
REQ-018 STOP: sample after DIV clocks; rxd=1 -> byte valid for one cycle; rxd=0 -> framing error for one cycle; either -> IDLE.
REQ-019 Loader FSM states: WAIT_HDR, LOAD; a 4-bit write pointer wptr.
REQ-020 WAIT_HDR: valid byte 8'hA5 -> LOAD with wptr=0 and loading=1 from the next cycle; any other byte is discarded.
REQ-021 LOAD: each valid byte writes mem[wptr] and increments wptr; a byte value of 8'hA5 is data, not a header.
REQ-022 The write at wptr=15 SHALL end the load: load_done=1 for exactly one cycle, loading=0, and the FSM returns to WAIT_HDR. wptr SHALL NOT wrap into a 17th write.
REQ-023 Framing error in LOAD SHALL abort the load: loading=0 and return to WAIT_HDR. Locations already written keep their new values.
REQ-024 err SHALL be set by any framing error and cleared only by reset or by reception of a valid header.
REQ-025 If a framing error and a header acceptance coincide, err SHALL stay set.
REQ-026 Memory reads while the loader writes the addressed location SHALL return the old value; this is unobservable because data is forced to 8'h00.

Reset
REQ-027 clr_n=0 SHALL asynchronously force: both FSMs to IDLE/WAIT_HDR, wptr=0, counters=0, synchronizer=1, loading=0, load_done=0, err=0, all 16 memory words=8'h00.
REQ-028 Reset asserted mid-byte or mid-load SHALL discard the partial byte and load. After release, the block SHALL require a fresh header.

Verification
REQ-029 Bench SHALL use CLK_HZ=16 and BAUD=1 (DIV=16).
REQ-030 Scenario: reset, then read all addresses -> data=8'h00 everywhere, loading=0, err=0.
REQ-031 Scenario: send A5, 00..0F as bytes 0x30+i -> loading rises after the header; load_done pulses once after the 16th stop bit; mem[i]=0x30+i; data follows addr.
REQ-032 Scenario: send 3C without a header -> no write, loading stays 0; then A5 followed by 16 bytes of A5 -> all words = 8'hA5.
REQ-033 Scenario: header, 5 bytes, then a byte with stop bit 0 -> err=1, loading=0, words 0-4 updated, words 5-15 unchanged; a subsequent A5 clears err.
REQ-034 Scenario: 4-clock low glitch on rxd while idle -> no byte received, no error.
REQ-035 Scenario: pulse clr_n low during byte 8 of a load -> all outputs 0 immediately, memory cleared; a full reload afterwards succeeds.

Source files
------------

// File: rtl/prog_loader.sv
// Purpose : UART (8N1) program loader that fills a 16x8 instruction memory read by the CPU.
// Latency : a byte takes effect about 9.5 bit periods after its start edge; data is combinational from addr.
// Backpress: none; the serial line cannot be stalled, and the CPU is held off with loading instead.
// Ports   : CLK, clr_n (async active-low reset), rxd (serial in), addr/data (CPU fetch),
//           loading (load in progress), load_done (1-cycle pulse), err (sticky framing error).
module prog_loader #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       CLK,
  input  logic       clr_n,
  input  logic       rxd,
  input  logic [3:0] addr,
  output logic [7:0] data,
  output logic       loading,
  output logic       load_done,
  output logic       err
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
  localparam logic [7:0]    HDR     = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {LD_WAIT_HDR, LD_LOAD} ld_state_t;

  rx_state_t rx_state, rx_next;
  ld_state_t ld_state, ld_next;

  logic          rxd_meta, rxd_sync;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic [3:0]    wptr;
  logic [7:0]    mem [16];

  logic cnt_clr, shift_en, byte_vld, frm_err;
  logic hdr_ok, wr_en, done_d;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK or negedge clr_n) begin
    if (!clr_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // Receiver state register
  always_ff @(posedge CLK or negedge clr_n) begin
    if (!clr_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // Receiver next-state. START waits half a bit so every later sample lands mid-bit.
  always_comb begin
    rx_next  = rx_state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    byte_vld = 1'b0;
    frm_err  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rxd_sync) begin
          rx_next = RX_START;
          cnt_clr = 1'b1;
        end
      end
      RX_START: begin
        if (cnt == HALF_M1) begin
          cnt_clr = 1'b1;
          rx_next = rxd_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bitn == 3'd7) rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_clr = 1'b1;
          rx_next = RX_IDLE;
          if (rxd_sync) byte_vld = 1'b1;
          else          frm_err  = 1'b1;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // Receiver datapath: bit-time counter, bit index and LSB-first shift register.
  always_ff @(posedge CLK or negedge clr_n) begin
    if (!clr_n) begin
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      if (cnt_clr || rx_state == RX_IDLE) cnt <= '0;
      else                                cnt <= cnt + 1'b1;
      if (rx_state == RX_IDLE) bitn <= '0;
      else if (shift_en)       bitn <= bitn + 1'b1;
      if (shift_en) shreg <= {rxd_sync, shreg[7:1]};
    end
  end

  // Loader state register
  always_ff @(posedge CLK or negedge clr_n) begin
    if (!clr_n) ld_state <= LD_WAIT_HDR;
    else        ld_state <= ld_next;
  end

  // Loader next-state. Inside LOAD every byte is payload, including 8'hA5.
  always_comb begin
    ld_next = ld_state;
    hdr_ok  = 1'b0;
    wr_en   = 1'b0;
    done_d  = 1'b0;
    case (ld_state)
      LD_WAIT_HDR: begin
        if (byte_vld && shreg == HDR) begin
          ld_next = LD_LOAD;
          hdr_ok  = 1'b1;
        end
      end
      LD_LOAD: begin
        if (byte_vld) begin
          wr_en = 1'b1;
          if (wptr == 4'hF) begin
            done_d  = 1'b1;
            ld_next = LD_WAIT_HDR;
          end
        end else if (frm_err) begin
          ld_next = LD_WAIT_HDR;
        end
      end
      default: ld_next = LD_WAIT_HDR;
    endcase
  end

  // Loader datapath. wptr wraps to 0 after the last write, but the FSM has
  // already left LOAD by then, so no 17th write can occur.
  always_ff @(posedge CLK or negedge clr_n) begin
    if (!clr_n) begin
      wptr      <= '0;
      load_done <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else begin
      load_done <= done_d;
      if (hdr_ok)     wptr <= '0;
      else if (wr_en) wptr <= wptr + 1'b1;
      if (wr_en) mem[wptr] <= shreg;
      // Setting has priority so a coincident header never hides an error.
      if (frm_err)     err <= 1'b1;
      else if (hdr_ok) err <= 1'b0;
    end
  end

  assign loading = (ld_state == LD_LOAD);
  assign data    = loading ? 8'h00 : mem[addr];

endmodule

// File: tb/tb_prog_loader.sv
// Purpose : self-checking bench for prog_loader with random payloads against a byte-level model.
// Latency : each serial byte is 10 bit periods of 16 clocks plus a short idle gap.
// Backpress: not applicable; stimulus is a linear sequence of directed steps.
module tb_prog_loader;

  logic       CLK   = 1'b0;
  logic       clr_n = 1'b0;
  logic       rxd   = 1'b1;
  logic [3:0] addr  = 4'h0;
  logic [7:0] data;
  logic       loading, load_done, err;

  prog_loader #(.CLK_HZ(16), .BAUD(1)) dut (
    .CLK       (CLK),
    .clr_n     (clr_n),
    .rxd       (rxd),
    .addr      (addr),
    .data      (data),
    .loading   (loading),
    .load_done (load_done),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed pulse activity: every high cycle of load_done counts, so a
  // stretched pulse shows up as an extra count.
  int done_cnt    = 0;
  int overlap_cnt = 0;
  always @(negedge CLK) begin
    if (load_done === 1'b1) done_cnt++;
    if (load_done === 1'b1 && loading === 1'b1) overlap_cnt++;
  end

  // Byte-level reference model
  logic [7:0] m_mem [16];
  bit         m_loading;
  bit         m_err;
  int         m_ptr;
  int         m_done;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_loading = 1'b0;
    m_err     = 1'b0;
    m_ptr     = 0;
  endtask

  task automatic model_rx(input logic [7:0] b, input bit good);
    if (!good) begin
      m_err     = 1'b1;
      m_loading = 1'b0;
    end else if (!m_loading) begin
      if (b == 8'hA5) begin
        m_loading = 1'b1;
        m_ptr     = 0;
        m_err     = 1'b0;
      end
    end else begin
      m_mem[m_ptr] = b;
      if (m_ptr == 15) begin
        m_loading = 1'b0;
        m_done++;
      end
      m_ptr++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // A bad frame holds the stop bit low only long enough to cover the sample
  // point, then idles long enough for any resulting false start to clear.
  task automatic send_byte(input logic [7:0] b, input bit good);
    @(negedge CLK);
    rxd = 1'b0;
    repeat (16) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (16) @(negedge CLK);
    end
    if (good) begin
      rxd = 1'b1;
      repeat (16) @(negedge CLK);
    end else begin
      rxd = 1'b0;
      repeat (12) @(negedge CLK);
      rxd = 1'b1;
      repeat (36) @(negedge CLK);
    end
    repeat (4) @(negedge CLK);
    model_rx(b, good);
  endtask

  task automatic check_mem(input string tag);
    int off;
    int idx;
    off = $urandom_range(0, 15);
    for (int i = 0; i < 16; i++) begin
      idx  = (off + i) % 16;
      addr = 4'(idx);
      #1;
      check($sformatf("%s[%0d]", tag, idx), {24'h0, data},
            m_loading ? 32'h0 : {24'h0, m_mem[idx]});
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".loading"}, {31'h0, loading}, {31'h0, m_loading});
    check({tag, ".err"},     {31'h0, err},     {31'h0, m_err});
    check({tag, ".done"},    done_cnt,         m_done);
    check({tag, ".overlap"}, overlap_cnt,      0);
  endtask

  task automatic send_random_load(input string tag);
    logic [7:0] b;
    send_byte(8'hA5, 1'b1);
    check({tag, ".hdr_loading"}, {31'h0, loading}, 32'h1);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1);
    end
    check_status(tag);
    check_mem(tag);
  endtask

  initial begin
    logic [7:0] b;
    m_done = 0;
    model_reset();

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst.load_done", {31'h0, load_done}, 32'h0);
    clr_n = 1'b1;
    repeat (3) @(negedge CLK);
    check_status("rst");
    check_mem("rst");

    // Sequential load 0x30+i
    send_byte(8'hA5, 1'b1);
    check("seq.hdr_loading", {31'h0, loading}, 32'h1);
    addr = 4'(3);
    #1;
    check("seq.data_held", {24'h0, data}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(8'h30 + i), 1'b1);
      if (i == 14) check("seq.loading_before_last", {31'h0, loading}, 32'h1);
    end
    check_status("seq");
    check_mem("seq");

    // Stray byte without a header, then a payload made entirely of A5
    send_byte(8'h3C, 1'b1);
    check_status("nohdr");
    check_mem("nohdr");
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'hA5, 1'b1);
    check_status("alla5");
    check_mem("alla5");

    // Framing error after 5 payload bytes
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    send_byte(8'($urandom), 1'b0);
    check_status("frm");
    check_mem("frm");
    send_byte(8'hA5, 1'b1);
    check_status("frm_clr");
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1);
    check_status("frm_reload");
    check_mem("frm_reload");

    // Short glitch between header and payload must not create a byte
    send_byte(8'hA5, 1'b1);
    @(negedge CLK);
    rxd = 1'b0;
    repeat (4) @(negedge CLK);
    rxd = 1'b1;
    repeat (40) @(negedge CLK);
    check_status("glitch_idle");
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1);
    check_status("glitch");
    check_mem("glitch");

    // Reset pulse partway through byte 8 of a load
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(1, 255)), 1'b1);
    @(negedge CLK);
    rxd = 1'b0;
    repeat (64) @(negedge CLK);
    #2;
    clr_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst.loading",   {31'h0, loading},   32'h0);
    check("mid_rst.load_done", {31'h0, load_done}, 32'h0);
    check("mid_rst.err",       {31'h0, err},       32'h0);
    rxd = 1'b1;
    check_mem("mid_rst_mem");
    repeat (2) @(negedge CLK);
    clr_n = 1'b1;
    repeat (4) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      while (b == 8'hA5) b = 8'($urandom);
      send_byte(b, 1'b1);
    end
    check_status("post_rst_nohdr");
    check_mem("post_rst_nohdr");
    send_random_load("reload");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
